// File: rtl/i2s_rx_sync_if.sv
// Bus bundle for i2s_rx_sync: serial I2S inputs, parallel stereo outputs, lock debug.
// The slave modport is the receiver's view; the master modport is the stream source and sink.
interface i2s_rx_sync_if #(
  parameter int PDATA_WIDTH = 32
);
  logic                   lrck_in;
  logic                   sclk_in;
  logic                   sdata_in;
  logic [PDATA_WIDTH-1:0] pldata_out;
  logic [PDATA_WIDTH-1:0] prdata_out;
  logic                   pvalid_out;
  logic                   locked_dbg;

  // pvalid_out is a one-cycle strobe with no ready: the consumer must take the
  // pair in the cycle it is high, and the pair holds until the next strobe.
  modport slave (
    input  lrck_in, sclk_in, sdata_in,
    output pldata_out, prdata_out, pvalid_out, locked_dbg
  );

  modport master (
    output lrck_in, sclk_in, sdata_in,
    input  pldata_out, prdata_out, pvalid_out, locked_dbg
  );
endinterface

// File: rtl/i2s_rx_sync.sv
// I2S receiver in the MCLK domain: samples LRCK/SCLK/SDATA as data and emits stereo word pairs.
// Define I2S_RX_SYNC_EN to add a two-flop synchroniser ahead of the input register.
module i2s_rx_sync #(
  parameter int PDATA_WIDTH = 32
) (
  input logic           mclk_in,
  input logic           srst_in,
  i2s_rx_sync_if.slave  bus
);
  localparam int CW = $clog2(PDATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(PDATA_WIDTH);
  localparam logic [CW-1:0] MSB_POS = CW'(PDATA_WIDTH - 1);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             in_s_q, in_s_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   lrck_p_q, lrck_p_d;
  logic [PDATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PDATA_WIDTH-1:0] hold_l_q, hold_l_d;
  logic                   left_seen_q, left_seen_d;
  logic [PDATA_WIDTH-1:0] pl_q, pl_d;
  logic [PDATA_WIDTH-1:0] pr_q, pr_d;
  logic                   pvalid_q, pvalid_d;

`ifdef I2S_RX_SYNC_EN
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
`endif

  logic                   lrck_s, sclk_s, sdata_s;
  logic                   rise, boundary, room;
  logic [PDATA_WIDTH-1:0] bit_word, shift_in;

  always_comb begin
`ifdef I2S_RX_SYNC_EN
    sync1_d = {bus.lrck_in, bus.sclk_in, bus.sdata_in};
    sync2_d = sync1_q;
    in_s_d  = sync2_q;
`else
    in_s_d  = {bus.lrck_in, bus.sclk_in, bus.sdata_in};
`endif
    lrck_s   = in_s_q[2];
    sclk_s   = in_s_q[1];
    sdata_s  = in_s_q[0];
    rise     = sclk_s & ~sclk_prev_q;
    boundary = (lrck_s != lrck_p_q);
    room     = (count_q < CNT_MAX);
    // MSB-first placement; bits past the word width are dropped via room.
    bit_word = {{(PDATA_WIDTH-1){1'b0}}, sdata_s} << (MSB_POS - count_q);
    shift_in = room ? (shift_q | bit_word) : shift_q;

    state_d     = state_q;
    sclk_prev_d = sclk_s;
    lrck_p_d    = lrck_p_q;
    shift_d     = shift_q;
    count_d     = count_q;
    hold_l_d    = hold_l_q;
    left_seen_d = left_seen_q;
    pl_d        = pl_q;
    pr_d        = pr_q;
    pvalid_d    = 1'b0;

    if (rise) begin
      lrck_p_d = lrck_s;
      if (boundary) begin
        // One-bit delay: this rise carries the LSB of the channel just ending.
        shift_d = '0;
        count_d = '0;
        if (state_q == ST_UNLOCKED) begin
          state_d = ST_LOCKED;
        end else if (!lrck_p_q) begin
          hold_l_d    = shift_in;
          left_seen_d = 1'b1;
        end else begin
          pl_d     = hold_l_q;
          pr_d     = shift_in;
          pvalid_d = left_seen_q;
        end
      end else begin
        shift_d = shift_in;
        if (room) count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge mclk_in) begin
    if (srst_in) begin
      state_q     <= ST_UNLOCKED;
      in_s_q      <= '0;
      sclk_prev_q <= 1'b0;
      lrck_p_q    <= 1'b0;
      shift_q     <= '0;
      count_q     <= '0;
      hold_l_q    <= '0;
      left_seen_q <= 1'b0;
      pl_q        <= '0;
      pr_q        <= '0;
      pvalid_q    <= 1'b0;
`ifdef I2S_RX_SYNC_EN
      sync1_q     <= '0;
      sync2_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_s_q      <= in_s_d;
      sclk_prev_q <= sclk_prev_d;
      lrck_p_q    <= lrck_p_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      hold_l_q    <= hold_l_d;
      left_seen_q <= left_seen_d;
      pl_q        <= pl_d;
      pr_q        <= pr_d;
      pvalid_q    <= pvalid_d;
`ifdef I2S_RX_SYNC_EN
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
`endif
    end
  end

  assign bus.pldata_out = pl_q;
  assign bus.prdata_out = pr_q;
  assign bus.pvalid_out = pvalid_q;
  assign bus.locked_dbg = (state_q == ST_LOCKED);
endmodule

// File: tb/tb_i2s_rx_sync.sv
// Bench for i2s_rx_sync: drives an I2S stream slot by slot and scores pairs against a slot-level model.
module tb_i2s_rx_sync;
  localparam int W = 32;
`ifdef I2S_RX_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic mclk = 1'b0;
  logic srst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int n_strobes = 0;

  i2s_rx_sync_if #(.PDATA_WIDTH(W)) bus ();
  i2s_rx_sync #(.PDATA_WIDTH(W)) dut (
    .mclk_in (mclk),
    .srst_in (srst),
    .bus     (bus)
  );

  always #5 mclk = ~mclk;

  // Reference model state: slot-level view of the stream.
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_pair;
  bit             m_locked, m_lrck_prev, m_left_seen, cur_partial;
  logic [W-1:0]   m_left;
  logic [63:0]    cur_w;
  int             cur_n;
  // Stream generator state.
  bit pend, fresh, open_ch;

  function automatic logic [W-1:0] slot_word(logic [63:0] w, int n);
    logic [63:0] t;
    if (n >= W) t = w >> (n - W);
    else        t = w << (W - n);
    return t[W-1:0];
  endfunction

  function automatic void model_reset();
    m_locked = 0; m_lrck_prev = 0; m_left_seen = 0; m_left = '0;
    cur_partial = 1; cur_w = '0; cur_n = 0;
  endfunction

  function automatic void model_commit(bit ch);
    logic [W-1:0] word;
    if (cur_partial) return;
    word = slot_word(cur_w, cur_n);
    if (!ch) begin
      m_left = word;
      m_left_seen = 1;
    end else if (m_left_seen) begin
      exp_q.push_back({m_left, word});
    end
  endfunction

  always @(negedge mclk) begin
    if (bus.pvalid_out === 1'b1) begin
      n_strobes++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_unexpected: got pl=%h pr=%h, required no strobe", bus.pldata_out, bus.prdata_out);
      end else begin
        exp_pair = exp_q.pop_front();
        if ({bus.pldata_out, bus.prdata_out} !== exp_pair) begin
          n_fail++;
          $display("FAIL strobe_pair: got pl=%h pr=%h, required pl=%h pr=%h",
                   bus.pldata_out, bus.prdata_out, exp_pair[2*W-1:W], exp_pair[W-1:0]);
        end
      end
    end
  end

  // One SCLK period: drive data during the low phase, then raise SCLK.
  task automatic sclk_period(bit lr, bit d, bit observe, bit rst_mid);
    @(posedge mclk); #1;
    bus.sclk_in = 1'b0;
    bus.lrck_in = lr;
    bus.sdata_in = d;
    if (rst_mid) begin
      repeat (3) @(posedge mclk);
      #1 srst = 1'b1;
      @(posedge mclk);
      #1 srst = 1'b0;
      n_tests += 4;
      if (bus.pldata_out !== '0) begin n_fail++; $display("FAIL midreset_pl: got %h, required 0", bus.pldata_out); end
      if (bus.prdata_out !== '0) begin n_fail++; $display("FAIL midreset_pr: got %h, required 0", bus.prdata_out); end
      if (bus.pvalid_out !== 1'b0) begin n_fail++; $display("FAIL midreset_pvalid: got %b, required 0", bus.pvalid_out); end
      if (bus.locked_dbg !== 1'b0) begin n_fail++; $display("FAIL midreset_locked: got %b, required 0", bus.locked_dbg); end
      repeat (3) @(posedge mclk);
    end else begin
      repeat ($urandom_range(2, 3)) @(posedge mclk);
    end
    #1 bus.sclk_in = 1'b1;
    if (observe) begin
      for (int j = 1; j <= 6; j++) begin
        @(posedge mclk);
        @(negedge mclk);
        n_tests++;
        if (bus.pvalid_out !== (j == LAT)) begin
          n_fail++;
          $display("FAIL latency_edge%0d: got pvalid=%b, required %b", j, bus.pvalid_out, (j == LAT));
        end
      end
    end else begin
      repeat ($urandom_range(1, 2)) @(posedge mclk);
    end
  endtask

  // First period of a slot: carries the previous slot's LSB under the new LRCK.
  task automatic begin_slot(bit c, bit observe);
    if (c != m_lrck_prev) begin
      if (m_locked) model_commit(m_lrck_prev);
      else m_locked = 1;
    end
    m_lrck_prev = c;
    cur_partial = 0;
    fresh = 1;
    open_ch = c;
    sclk_period(c, pend, observe, 1'b0);
  endtask

  task automatic send_slot(bit c, logic [63:0] w, int n, int rst_at);
    if (!(fresh && open_ch == c)) begin_slot(c, 1'b0);
    fresh = 0;
    cur_w = w;
    cur_n = n;
    for (int i = 1; i < n; i++) begin
      bit b;
      b = w[6'(n - i)];
      if (i == rst_at) begin
        // After reset the receiver relocks on this slot's next rise; the slot is partial.
        m_left_seen = 0; m_left = '0; cur_partial = 1;
        m_locked = c; m_lrck_prev = c;
      end
      sclk_period(c, b, 1'b0, (i == rst_at));
    end
    pend = w[0];
  endtask

  function automatic logic [63:0] rand_word(int n);
    logic [63:0] w;
    w = {$urandom, $urandom};
    if (n < 64) w = w & ((64'd1 << n) - 64'd1);
    return w;
  endfunction

  task automatic pulse_reset();
    @(posedge mclk); #1;
    bus.sclk_in = 1'b0; bus.lrck_in = 1'b0; bus.sdata_in = 1'b0;
    srst = 1'b1;
    repeat (2) @(posedge mclk);
    #1 srst = 1'b0;
    model_reset();
    exp_q.delete();
    pend = 0; fresh = 0; open_ch = 0;
  endtask

  task automatic settle();
    repeat (6) @(posedge mclk);
    #1;
  endtask

  task automatic check_pair(string name, int s0, int n_exp, logic [W-1:0] l, logic [W-1:0] r);
    n_tests += 3;
    if (n_strobes - s0 !== n_exp) begin n_fail++; $display("FAIL %s_count: got %0d strobes, required %0d", name, n_strobes - s0, n_exp); end
    if (bus.pldata_out !== l) begin n_fail++; $display("FAIL %s_left: got %h, required %h", name, bus.pldata_out, l); end
    if (bus.prdata_out !== r) begin n_fail++; $display("FAIL %s_right: got %h, required %h", name, bus.prdata_out, r); end
  endtask

  task automatic test_reset();
    bus.sclk_in = 1'b0; bus.lrck_in = 1'b0; bus.sdata_in = 1'b0;
    srst = 1'b1;
    repeat (4) @(posedge mclk);
    #1 srst = 1'b0;
    n_tests += 4;
    if (bus.pldata_out !== '0) begin n_fail++; $display("FAIL reset_pl: got %h, required 0", bus.pldata_out); end
    if (bus.prdata_out !== '0) begin n_fail++; $display("FAIL reset_pr: got %h, required 0", bus.prdata_out); end
    if (bus.pvalid_out !== 1'b0) begin n_fail++; $display("FAIL reset_pvalid: got %b, required 0", bus.pvalid_out); end
    if (bus.locked_dbg !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b, required 0", bus.locked_dbg); end
    model_reset();
    pend = 0; fresh = 0; open_ch = 0;
  endtask

  task automatic test_lock();
    int s0;
    pulse_reset();
    s0 = n_strobes;
    send_slot(1'b0, rand_word(13), 13, -1);
    send_slot(1'b1, rand_word(W), W, -1);
    send_slot(1'b0, 64'hA5A5_0001, W, -1);
    send_slot(1'b1, 64'h5A5A_8000, W, -1);
    begin_slot(1'b0, 1'b0);
    settle();
    check_pair("lock", s0, 1, 32'hA5A5_0001, 32'h5A5A_8000);
  endtask

  task automatic test_latency();
    send_slot(1'b0, rand_word(W), W, -1);
    send_slot(1'b1, rand_word(W), W, -1);
    begin_slot(1'b0, 1'b1);
  endtask

  task automatic test_short_word();
    int s0;
    s0 = n_strobes;
    send_slot(1'b0, 64'hAB_CDEF, 24, -1);
    send_slot(1'b1, 64'h12_3456, 24, -1);
    begin_slot(1'b0, 1'b0);
    settle();
    check_pair("short", s0, 1, 32'hABCD_EF00, 32'h1234_5600);
  endtask

  task automatic test_long_word();
    int s0;
    s0 = n_strobes;
    send_slot(1'b0, {30'd0, 32'hDEAD_BEEF, 2'b11}, 34, -1);
    send_slot(1'b1, {30'd0, 32'hCAFE_F00D, 2'b11}, 34, -1);
    begin_slot(1'b0, 1'b0);
    settle();
    check_pair("long", s0, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
  endtask

  task automatic test_reset_mid();
    int s0;
    logic [W-1:0] l, r;
    s0 = n_strobes;
    l = $urandom; r = $urandom;
    send_slot(1'b0, rand_word(W), W, -1);
    send_slot(1'b1, rand_word(W), W, $urandom_range(5, 20));
    send_slot(1'b0, {32'd0, l}, W, -1);
    send_slot(1'b1, {32'd0, r}, W, -1);
    begin_slot(1'b0, 1'b0);
    settle();
    check_pair("reset_mid", s0, 1, l, r);
  endtask

  task automatic test_back_to_back();
    int s0;
    logic [W-1:0] base;
    s0 = n_strobes;
    base = $urandom & 32'hFFFF_FF00;
    for (int k = 0; k < 8; k++) begin
      send_slot(1'b0, {32'd0, base + W'(2 * k)}, W, -1);
      send_slot(1'b1, {32'd0, base + W'(2 * k + 1)}, W, -1);
    end
    begin_slot(1'b0, 1'b0);
    settle();
    check_pair("back_to_back", s0, 8, base + W'(14), base + W'(15));
  endtask

  task automatic test_random_lengths();
    int s0;
    int nl, nr;
    logic [63:0] wl, wr;
    s0 = n_strobes;
    for (int k = 0; k < 6; k++) begin
      nl = $urandom_range(16, 40); nr = $urandom_range(16, 40);
      wl = rand_word(nl); wr = rand_word(nr);
      send_slot(1'b0, wl, nl, -1);
      send_slot(1'b1, wr, nr, -1);
    end
    begin_slot(1'b0, 1'b0);
    settle();
    check_pair("random_len", s0, 6, slot_word(wl, nl), slot_word(wr, nr));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock();
    test_latency();
    test_short_word();
    test_long_word();
    test_reset_mid();
    test_back_to_back();
    test_random_lengths();
    settle();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expected: got %0d unmatched pairs, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
